// File: rtl/sys_clk_sched_pkg.sv
// Shared constants and types for the interval-timer scheduler: timer register
// map, control-word bits and the sequencing FSM state encoding.
package sys_clk_sched_pkg;

    localparam logic [2:0] TMR_STATUS  = 3'd0;
    localparam logic [2:0] TMR_CONTROL = 3'd1;
    localparam logic [2:0] TMR_PERIODL = 3'd2;
    localparam logic [2:0] TMR_PERIODH = 3'd3;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    localparam logic [15:0] CTL_WORD_STOP  = 16'h0001 << CTL_STOP;
    localparam logic [15:0] CTL_WORD_START = (16'h0001 << CTL_START) | (16'h0001 << CTL_ITO);

    localparam int MIN_DELAY = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARB,
        S_STOP,
        S_WR_PL,
        S_WR_PH,
        S_SETTLE,
        S_START,
        S_WAIT,
        S_CLR,
        S_DONE,
        S_ABORT_STOP
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer for the first eligible
// request; the pointer moves to the channel after the winner on advance.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  eligible_i,
    input  logic          advance_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;
    logic [N-1:0]  cand_s;
    logic          found_s;
    int            pos_s;

    // Rotating priority search starting at the pointer
    always_comb begin
        cand_s  = req_i & eligible_i;
        gnt_o   = '0;
        idx_o   = '0;
        found_s = 1'b0;
        pos_s   = 0;
        for (int k = 0; k < N; k++) begin
            pos_s = (int'(ptr_q) + k) % N;
            if (!found_s && cand_s[pos_s]) begin
                found_s       = 1'b1;
                gnt_o[pos_s]  = 1'b1;
                idx_o         = IW'(pos_s);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Pointer next value
    always_comb begin
        if (advance_i) begin
            ptr_d = (idx_o == IW'(N - 1)) ? '0 : idx_o + IW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sys_clk_scheduler.sv
// Shares one Avalon-MM interval timer among N one-shot delay requesters by
// sequencing stop / load / start / wait-irq / clear writes to the timer.
module sys_clk_scheduler
    import sys_clk_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic [N*CW-1:0] delay,
    output logic [N-1:0]  grant,
    output logic [N-1:0]  done,
    output logic          busy,
    output logic [2:0]    tmr_address,
    output logic          tmr_chipselect,
    output logic          tmr_write_n,
    output logic [15:0]   tmr_writedata,
    input  logic          tmr_irq
);

    localparam int IW = $clog2(N);

    sched_state_e  state_q, state_d;
    logic [IW-1:0] ch_q, ch_d;
    logic [CW-1:0] period_q, period_d;
    logic          abort_q, abort_d;
    logic [N-1:0]  lockout_q, lockout_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [N-1:0]  done_q, done_d;
    logic          busy_q, busy_d;
    logic          cs_q, cs_d;
    logic          wrn_q, wrn_d;
    logic [2:0]    addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;

    logic [N-1:0]  arb_gnt_s;
    logic [IW-1:0] arb_idx_s;
    logic          advance_s;
    logic [CW-1:0] sel_delay_s;
    logic [CW-1:0] eff_s;
    logic          req_ch_s;
    logic [31:0]   per32_s;

    rr_arbiter #(.N(N), .IW(IW)) u_arb (
        .clk        (clk),
        .rst_n      (reset_n),
        .req_i      (req),
        .eligible_i (~lockout_q),
        .advance_i  (advance_s),
        .gnt_o      (arb_gnt_s),
        .idx_o      (arb_idx_s)
    );

    assign sel_delay_s = delay[int'(arb_idx_s) * CW +: CW];
    assign eff_s       = (sel_delay_s < CW'(MIN_DELAY)) ? CW'(MIN_DELAY) : sel_delay_s;
    assign req_ch_s    = req[ch_q];
    assign per32_s     = 32'(period_q);

    // Sequencing FSM next state; abort_q remembers a request drop before START
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        period_d  = period_q;
        abort_d   = abort_q;
        advance_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                if (|arb_gnt_s) begin
                    advance_s = 1'b1;
                    ch_d      = arb_idx_s;
                    period_d  = eff_s - CW'(1);
                    state_d   = S_ARB;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARB:   state_d = S_STOP;
            S_STOP: begin
                abort_d = abort_q | ~req_ch_s;
                state_d = S_WR_PL;
            end
            S_WR_PL: begin
                abort_d = abort_q | ~req_ch_s;
                state_d = S_WR_PH;
            end
            S_WR_PH: begin
                abort_d = abort_q | ~req_ch_s;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (abort_q || !req_ch_s) begin
                    abort_d = 1'b1;
                    state_d = S_ABORT_STOP;
                end else begin
                    state_d = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                // irq has priority over a simultaneous request drop
                if (tmr_irq) begin
                    state_d = S_CLR;
                end else if (!req_ch_s) begin
                    abort_d = 1'b1;
                    state_d = S_ABORT_STOP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ABORT_STOP: state_d = S_CLR;
            S_CLR: begin
                if (abort_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lockout: set when done fires with req still high, cleared once req is seen low
    always_comb begin
        lockout_d = lockout_q;
        for (int i = 0; i < N; i++) begin
            if (state_q == S_DONE && ch_q == IW'(i) && req[i]) begin
                lockout_d[i] = 1'b1;
            end else if (!req[i]) begin
                lockout_d[i] = 1'b0;
            end else begin
                lockout_d[i] = lockout_q[i];
            end
        end
    end

    // Output next values, decoded from the upcoming state so outputs can be registered
    always_comb begin
        grant_d = advance_s ? arb_gnt_s : '0;
        done_d  = (state_d == S_DONE) ? ({{(N-1){1'b0}}, 1'b1} << ch_q) : '0;
        busy_d  = (state_d != S_IDLE);
        cs_d    = 1'b1;
        wrn_d   = 1'b0;
        addr_d  = 3'd0;
        wdata_d = 16'h0000;
        case (state_d)
            S_STOP, S_ABORT_STOP: begin
                addr_d  = TMR_CONTROL;
                wdata_d = CTL_WORD_STOP;
            end
            S_WR_PL: begin
                addr_d  = TMR_PERIODL;
                wdata_d = per32_s[15:0];
            end
            S_WR_PH: begin
                addr_d  = TMR_PERIODH;
                wdata_d = per32_s[31:16];
            end
            S_START: begin
                addr_d  = TMR_CONTROL;
                wdata_d = CTL_WORD_START;
            end
            S_CLR: begin
                addr_d  = TMR_STATUS;
                wdata_d = 16'h0000;
            end
            default: begin
                cs_d  = 1'b0;
                wrn_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            ch_q      <= '0;
            period_q  <= '0;
            abort_q   <= 1'b0;
            lockout_q <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            busy_q    <= 1'b0;
            cs_q      <= 1'b0;
            wrn_q     <= 1'b1;
            addr_q    <= 3'd0;
            wdata_q   <= 16'h0000;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            period_q  <= period_d;
            abort_q   <= abort_d;
            lockout_q <= lockout_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            cs_q      <= cs_d;
            wrn_q     <= wrn_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign grant          = grant_q;
    assign done           = done_q;
    assign busy           = busy_q;
    assign tmr_chipselect = cs_q;
    assign tmr_write_n    = wrn_q;
    assign tmr_address    = addr_q;
    assign tmr_writedata  = wdata_q;

endmodule
